// File: rtl/memory_stage_pkg.sv
// Shared widths, opcode constants and memory-op decode for the memory stage.
// Decode is kept here so the stage and any future consumer agree on sizes.
package memory_stage_pkg;

  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    logic      is_signed;
    mem_size_e size;
  } mem_ctl_t;

  function automatic mem_ctl_t decode_op(input logic [OPCODE_WIDTH-1:0] op);
    mem_ctl_t ctl;
    ctl = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SIZE_WORD};
    case (op)
      OP_LB:   ctl = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SIZE_BYTE};
      OP_LH:   ctl = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SIZE_HALF};
      OP_LW:   ctl = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SIZE_WORD};
      OP_LBU:  ctl = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SIZE_BYTE};
      OP_LHU:  ctl = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SIZE_HALF};
      OP_SB:   ctl = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SIZE_BYTE};
      OP_SH:   ctl = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SIZE_HALF};
      OP_SW:   ctl = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SIZE_WORD};
      default: ctl = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SIZE_WORD};
    endcase
    return ctl;
  endfunction

  // Byte accesses can never be misaligned; only memory ops are checked.
  function automatic logic is_misaligned(input mem_ctl_t ctl, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (ctl.is_load || ctl.is_store) begin
      case (ctl.size)
        SIZE_HALF: mis = offset[0];
        SIZE_WORD: mis = |offset;
        default:   mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-lane-writable synchronous RAM with a registered read port.
// Contents are deliberately not reset.
module data_mem
  import memory_stage_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
    end
    if (rd_en) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: alignment check, byte-lane store decode and load
// extension around a single-cycle data RAM.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic                    ms_i_clk,
  input  logic                    ms_i_rst,
  input  logic                    ms_i_ce,
  input  logic                    ms_i_stall,
  input  logic                    ms_i_flush,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_data_rt,
  input  logic [4:0]              ms_i_rd_addr,
  input  logic                    ms_i_regwrite,
  output logic                    ms_o_ce,
  output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic [DWIDTH-1:0]       ms_o_alu_value,
  output logic [4:0]              ms_o_rd_addr,
  output logic                    ms_o_regwrite,
  output logic                    ms_o_memtoreg,
  output logic [DWIDTH-1:0]       ms_o_load_data,
  output logic                    ms_o_misalign
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic                    accept;
  mem_ctl_t                in_ctl;
  mem_ctl_t                out_ctl;
  logic [1:0]              in_offset;
  logic                    in_misalign;
  logic [3:0]              lane_we;
  logic [DWIDTH-1:0]       lane_wdata;
  logic [DWIDTH-1:0]       rdata;
  logic [DWIDTH-1:0]       shifted;

  logic                    ce_d, ce_q;
  logic [OPCODE_WIDTH-1:0] opcode_d, opcode_q;
  logic [DWIDTH-1:0]       alu_value_d, alu_value_q;
  logic [4:0]              rd_addr_d, rd_addr_q;
  logic                    regwrite_d, regwrite_q;
  logic                    memtoreg_d, memtoreg_q;
  logic                    misalign_d, misalign_q;
  logic [1:0]              offset_d, offset_q;

  assign accept      = !ms_i_rst && !ms_i_stall && !ms_i_flush;
  assign in_ctl      = decode_op(ms_i_opcode);
  assign in_offset   = ms_i_alu_value[1:0];
  assign in_misalign = is_misaligned(in_ctl, in_offset);

  // Lane enables only fire on an accepted, valid, aligned store.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = ms_i_data_rt;
    case (in_ctl.size)
      SIZE_BYTE: lane_wdata = {4{ms_i_data_rt[7:0]}};
      SIZE_HALF: lane_wdata = {2{ms_i_data_rt[15:0]}};
      default:   lane_wdata = ms_i_data_rt;
    endcase
    if (accept && ms_i_ce && in_ctl.is_store && !in_misalign) begin
      case (in_ctl.size)
        SIZE_BYTE: lane_we = 4'b0001 << in_offset;
        SIZE_HALF: lane_we = 4'b0011 << in_offset;
        default:   lane_we = 4'b1111;
      endcase
    end
  end

  data_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clk   (ms_i_clk),
    .rd_en (accept),
    .we    (lane_we),
    .addr  (ms_i_alu_value[AW+1:2]),
    .wdata (lane_wdata),
    .rdata (rdata)
  );

  // Flush only clears the valid-style flags; stall holds everything.
  always_comb begin
    ce_d        = ce_q;
    opcode_d    = opcode_q;
    alu_value_d = alu_value_q;
    rd_addr_d   = rd_addr_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    misalign_d  = misalign_q;
    offset_d    = offset_q;
    if (ms_i_flush) begin
      ce_d       = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      misalign_d = 1'b0;
    end else if (!ms_i_stall) begin
      ce_d        = ms_i_ce;
      opcode_d    = ms_i_opcode;
      alu_value_d = ms_i_alu_value;
      rd_addr_d   = ms_i_rd_addr;
      regwrite_d  = ms_i_ce && ms_i_regwrite && !in_misalign;
      memtoreg_d  = ms_i_ce && in_ctl.is_load;
      misalign_d  = ms_i_ce && in_misalign;
      offset_d    = in_offset;
    end
  end

  always_ff @(posedge ms_i_clk) begin
    if (ms_i_rst) begin
      ce_q        <= 1'b0;
      opcode_q    <= '0;
      alu_value_q <= '0;
      rd_addr_q   <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      misalign_q  <= 1'b0;
      offset_q    <= '0;
    end else begin
      ce_q        <= ce_d;
      opcode_q    <= opcode_d;
      alu_value_q <= alu_value_d;
      rd_addr_q   <= rd_addr_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      misalign_q  <= misalign_d;
      offset_q    <= offset_d;
    end
  end

  assign out_ctl = decode_op(opcode_q);
  assign shifted = rdata >> {offset_q, 3'b000};

  always_comb begin
    ms_o_load_data = '0;
    if (ce_q && out_ctl.is_load && !misalign_q) begin
      case (out_ctl.size)
        SIZE_BYTE: ms_o_load_data = out_ctl.is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                                      : {24'h0, shifted[7:0]};
        SIZE_HALF: ms_o_load_data = out_ctl.is_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                                      : {16'h0, shifted[15:0]};
        default:   ms_o_load_data = rdata;
      endcase
    end
  end

  assign ms_o_ce        = ce_q;
  assign ms_o_opcode    = opcode_q;
  assign ms_o_alu_value = alu_value_q;
  assign ms_o_rd_addr   = rd_addr_q;
  assign ms_o_regwrite  = regwrite_q;
  assign ms_o_memtoreg  = memtoreg_q;
  assign ms_o_misalign  = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized checks of memory_stage against a byte-addressed
// reference memory and an instruction-level output model.
module tb_memory_stage;

  localparam int MEM_DEPTH = 1024;
  localparam int NBYTES    = 4 * MEM_DEPTH;

  logic        clk = 1'b0;
  logic        rst, ce, stall, flush, regwrite;
  logic [5:0]  opcode;
  logic [31:0] aluValue, dataRt;
  logic [4:0]  rdAddr;

  logic        oCe, oRegwrite, oMemtoreg, oMisalign;
  logic [5:0]  oOpcode;
  logic [31:0] oAluValue, oLoadData;
  logic [4:0]  oRdAddr;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  modelMem [NBYTES];
  logic        expCe, expRegwrite, expMemtoreg, expMisalign, expFieldsValid;
  logic [5:0]  expOpcode;
  logic [31:0] expAlu, expLoad;
  logic [4:0]  expRd;
  logic [5:0]  opList [12];

  memory_stage #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .ms_i_clk       (clk),
    .ms_i_rst       (rst),
    .ms_i_ce        (ce),
    .ms_i_stall     (stall),
    .ms_i_flush     (flush),
    .ms_i_opcode    (opcode),
    .ms_i_alu_value (aluValue),
    .ms_i_data_rt   (dataRt),
    .ms_i_rd_addr   (rdAddr),
    .ms_i_regwrite  (regwrite),
    .ms_o_ce        (oCe),
    .ms_o_opcode    (oOpcode),
    .ms_o_alu_value (oAluValue),
    .ms_o_rd_addr   (oRdAddr),
    .ms_o_regwrite  (oRegwrite),
    .ms_o_memtoreg  (oMemtoreg),
    .ms_o_load_data (oLoadData),
    .ms_o_misalign  (oMisalign)
  );

  always #5 clk = ~clk;

  function automatic int accessSize(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  // Model of one clock edge at instruction level on a byte-addressed memory.
  task automatic modelStep(input logic r, input logic c, input logic s, input logic f,
                           input logic [5:0] op, input logic [31:0] alu,
                           input logic [31:0] rt, input logic [4:0] rd, input logic rw);
    int size, addr;
    logic isLoad, isStore, isSigned, mis;
    logic [31:0] val;
    size     = accessSize(op);
    isLoad   = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    isStore  = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    isSigned = (op == 6'h20) || (op == 6'h21);
    addr     = int'(alu % NBYTES);
    mis      = c && (size > 1) && ((addr % size) != 0);
    if (r) begin
      {expCe, expRegwrite, expMemtoreg, expMisalign} = 4'b0;
      expOpcode = '0; expAlu = '0; expRd = '0; expLoad = '0;
      expFieldsValid = 1'b1;
    end else if (f) begin
      {expCe, expRegwrite, expMemtoreg, expMisalign} = 4'b0;
      expLoad = '0;
      expFieldsValid = 1'b0;
    end else if (!s) begin
      expCe = c; expOpcode = op; expAlu = alu; expRd = rd;
      expRegwrite = c && rw && !mis;
      expMemtoreg = c && isLoad;
      expMisalign = mis;
      expFieldsValid = 1'b1;
      expLoad = '0;
      if (c && isLoad && !mis) begin
        val = '0;
        for (int i = 0; i < size; i++) val = val + (32'(modelMem[addr + i]) << (8 * i));
        if (isSigned && val[8*size-1]) val = val - (32'h1 << (8 * size));
        expLoad = val;
      end
      if (c && isStore && !mis) begin
        for (int i = 0; i < size; i++) modelMem[addr + i] = rt[8*i +: 8];
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".ce"},        32'(oCe),        32'(expCe));
    checkOne({tag, ".regwrite"},  32'(oRegwrite),  32'(expRegwrite));
    checkOne({tag, ".memtoreg"},  32'(oMemtoreg),  32'(expMemtoreg));
    checkOne({tag, ".misalign"},  32'(oMisalign),  32'(expMisalign));
    checkOne({tag, ".load_data"}, oLoadData,       expLoad);
    if (expFieldsValid) begin
      checkOne({tag, ".opcode"},    32'(oOpcode),   32'(expOpcode));
      checkOne({tag, ".alu_value"}, oAluValue,      expAlu);
      checkOne({tag, ".rd_addr"},   32'(oRdAddr),   32'(expRd));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic c, input logic s,
                               input logic f, input logic [5:0] op, input logic [31:0] alu,
                               input logic [31:0] rt, input logic [4:0] rd, input logic rw);
    rst = r; ce = c; stall = s; flush = f; opcode = op;
    aluValue = alu; dataRt = rt; rdAddr = rd; regwrite = rw;
    modelStep(r, c, s, f, op, alu, rt, rd, rw);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    opList = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
               6'h00, 6'h0F, 6'h22, 6'h2A};
    for (int i = 0; i < NBYTES; i++) modelMem[i] = 8'h00;
    $display("[TB] start");

    applyStimulus("reset0", 1, 1, 0, 0, 6'h2B, 32'h0, 32'h1, 5'd3, 1);
    applyStimulus("reset1", 1, 0, 0, 0, 6'h00, 32'h0, 32'h0, 5'd0, 0);

    for (int w = 0; w < 16; w++)
      applyStimulus("init", 0, 1, 0, 0, 6'h2B, 32'(4 * w), $urandom, 5'd0, 0);

    applyStimulus("sw_deadbeef", 0, 1, 0, 0, 6'h2B, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    applyStimulus("lw_0x10", 0, 1, 0, 0, 6'h23, 32'h10, 32'h0, 5'd4, 1);
    checkOne("lw_0x10.const", oLoadData, 32'hDEADBEEF);
    checkOne("lw_0x10.memtoreg_const", 32'(oMemtoreg), 32'd1);
    checkOne("lw_0x10.regwrite_const", 32'(oRegwrite), 32'd1);
    applyStimulus("lb_0x13", 0, 1, 0, 0, 6'h20, 32'h13, 32'h0, 5'd5, 1);
    checkOne("lb_0x13.const", oLoadData, 32'hFFFFFFDE);
    applyStimulus("lbu_0x13", 0, 1, 0, 0, 6'h24, 32'h13, 32'h0, 5'd5, 1);
    checkOne("lbu_0x13.const", oLoadData, 32'h000000DE);
    applyStimulus("lh_0x10", 0, 1, 0, 0, 6'h21, 32'h10, 32'h0, 5'd6, 1);
    checkOne("lh_0x10.const", oLoadData, 32'hFFFFBEEF);
    applyStimulus("lhu_0x12", 0, 1, 0, 0, 6'h25, 32'h12, 32'h0, 5'd6, 1);
    checkOne("lhu_0x12.const", oLoadData, 32'h0000DEAD);
    applyStimulus("sb_0x11", 0, 1, 0, 0, 6'h28, 32'h11, 32'h55, 5'd0, 0);
    applyStimulus("lw_after_sb", 0, 1, 0, 0, 6'h23, 32'h10, 32'h0, 5'd7, 1);
    checkOne("lw_after_sb.const", oLoadData, 32'hDEAD55EF);

    applyStimulus("lw_mis_0x12", 0, 1, 0, 0, 6'h23, 32'h12, 32'h0, 5'd8, 1);
    checkOne("lw_mis.misalign_const", 32'(oMisalign), 32'd1);
    applyStimulus("sh_mis_0x11", 0, 1, 0, 0, 6'h29, 32'h11, 32'hAAAA, 5'd0, 0);
    applyStimulus("lw_after_sh_mis", 0, 1, 0, 0, 6'h23, 32'h10, 32'h0, 5'd8, 1);
    checkOne("lw_after_sh_mis.const", oLoadData, 32'hDEAD55EF);

    for (int k = 0; k < 3; k++)
      applyStimulus("sw_stalled", 0, 1, 1, 0, 6'h2B, 32'h20, 32'h12345678, 5'd0, 0);
    applyStimulus("sw_flushed", 0, 1, 1, 1, 6'h2B, 32'h20, 32'h12345678, 5'd0, 0);
    applyStimulus("lw_after_flush", 0, 1, 0, 0, 6'h23, 32'h20, 32'h0, 5'd9, 1);

    applyStimulus("sw_in_reset", 1, 1, 0, 0, 6'h2B, 32'h20, 32'hCAFEF00D, 5'd0, 0);
    applyStimulus("lw_after_reset", 0, 1, 0, 0, 6'h23, 32'h20, 32'h0, 5'd9, 1);
    applyStimulus("nop_passthru", 0, 1, 0, 0, 6'h00, 32'h1234, 32'h0, 5'd10, 1);
    checkOne("nop_passthru.alu_const", oAluValue, 32'h1234);

    applyStimulus("stall_pre_reset", 0, 1, 1, 0, 6'h28, 32'h24, 32'h77, 5'd0, 0);
    applyStimulus("reset_in_stall", 1, 1, 1, 0, 6'h28, 32'h24, 32'h77, 5'd0, 0);
    applyStimulus("sb_post_reset", 0, 1, 0, 0, 6'h28, 32'h25, 32'h99, 5'd0, 0);
    applyStimulus("lw_post_reset", 0, 1, 0, 0, 6'h23, 32'h24, 32'h0, 5'd11, 1);

    for (int n = 0; n < 400; n++) begin
      logic r, c, s, f;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 10);
      f = ($urandom_range(0, 99) < 5);
      applyStimulus("random", r, c, s, f, opList[$urandom_range(0, 11)],
                    ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                    $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, data memory size in 32-bit words; SHALL be a power of two.
REQ-002 ms_i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 ms_i_rst  input  1  reset, synchronous and active-high.
REQ-004 ms_i_ce  input  1  valid instruction from execute stage.
REQ-005 ms_i_stall  input  1  hold stage, suppress memory write.
REQ-006 ms_i_flush  input  1  kill incoming instruction.
REQ-007 ms_i_opcode  input  `OPCODE_WIDTH  instruction opcode from execute.
REQ-008 ms_i_alu_value  input  `DWIDTH  byte address for loads/stores, else ALU result.
REQ-009 ms_i_data_rt  input  `DWIDTH  store data.
REQ-010 ms_i_rd_addr  input  5  destination register.
REQ-011 ms_i_regwrite  input  1  instruction writes register file.
REQ-012 ms_o_ce  output  1  valid instruction to writeback.
REQ-013 ms_o_opcode / ms_o_alu_value / ms_o_rd_addr  output  `OPCODE_WIDTH / `DWIDTH / 5  registered copies of inputs.
REQ-014 ms_o_regwrite  output  1  registered write enable, gated per REQ-022.
REQ-015 ms_o_memtoreg  output  1  high when the instruction is a load.
REQ-016 ms_o_load_data  output  `DWIDTH  extended load result.
REQ-017 ms_o_misalign  output  1  misaligned access flag.

Function
REQ-018 Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25; stores: SB 0x28, SH 0x29, SW 0x2B; all other opcodes are non-memory and pass through.
REQ-019 Word index = ms_i_alu_value[log2(MEM_DEPTH)+1:2]; upper address bits ignored (wraps modulo memory size); byte offset = bits [1:0], little-endian (byte n = bits 8n+7:8n).
REQ-020 Accepted cycle = rising edge with ms_i_rst=0, ms_i_stall=0, ms_i_flush=0; all output registers load on accepted cycles; latency exactly 1 cycle.
REQ-021 Misaligned: LW/SW with offset!=0, LH/LHU/SH with offset[0]!=0; byte ops never misaligned.
REQ-022 Output register ms_o_regwrite = ms_i_ce & ms_i_regwrite & !misaligned.
REQ-023 Store write on accepted cycle when ms_i_ce=1 and not misaligned: SW all 4 lanes, SH lanes {offset+1,offset} from data_rt[15:0], SB lane offset from data_rt[7:0]; other lanes unchanged.
REQ-024 Memory read synchronous on accepted cycle; ms_o_load_data formed from registered word and registered offset: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-025 ms_o_load_data = 0 when ms_o_ce=0, on non-load opcodes, or when ms_o_misalign=1.
REQ-026 Store at edge N followed by load of same word at edge N+1 SHALL return the new data.
REQ-027 Stall: all output registers and memory hold; stall with ms_i_ce=1 SHALL NOT write memory.
REQ-028 Flush (priority over stall): ms_o_ce, ms_o_regwrite, ms_o_memtoreg, ms_o_misalign cleared on next edge; no memory write.
REQ-029 ms_o_misalign asserted with ms_o_ce=1 for exactly the offending instruction's output cycle.

Reset
REQ-030 Reset priority over flush and stall; all outputs become 0 on the edge it is sampled.
REQ-031 Memory contents NOT cleared by reset; stores in a reset cycle are suppressed.
REQ-032 Reset asserted mid-stall releases the stall state; first accepted cycle after reset behaves normally.

Structure
REQ-033 Opcode constants, `DWIDTH, `OPCODE_WIDTH in shared header.vh; MEM_DEPTH local parameter overridable.
REQ-034 One sub-module data_mem: synchronous RAM, 4 byte-lane enables, registered read, no reset.
REQ-035 Alignment check, lane-enable decode, load extension live in memory_stage.

Verification
REQ-036 SW 0xDEADBEEF to addr 0x10, LW addr 0x10 next cycle -> load_data 0xDEADBEEF, memtoreg=1, regwrite=1.
REQ-037 After REQ-036: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-038 SB 0x55 to 0x11 then LW 0x10 -> 0xDEAD55EF.
REQ-039 LW addr 0x12 -> misalign=1, regwrite=0, load_data=0; SH addr 0x11 -> misalign=1, memory word unchanged.
REQ-040 SW with stall=1 for 3 cycles then flush=1 -> no write, outputs frozen during stall, ms_o_ce=0 after flush.
REQ-041 Reset during valid SW -> outputs 0, memory unchanged; opcode 0x00 with alu_value 0x1234 -> alu_value passes 0x1234 after 1 cycle, load_data 0.
